// File: rtl/mux2to1_rr_sched_pkg.sv
// Shared definitions for the L2 round-robin byte scheduler: default sizes,
// scheduler state encoding and the round-robin lane pick.
package mux2to1_rr_sched_pkg;

   localparam int DATA_W_L2 = 8;  // byte width per lane
   localparam int DEPTH_L2  = 4;  // entries per lane FIFO (power of 2, >= 2)
   localparam int AW_L2     = 2;  // log2(DEPTH_L2)

   typedef enum logic {
      ST_IDLE = 1'b0,  // output register holds no valid byte
      ST_SEND = 1'b1   // output register holds a valid byte
   } sched_state_e;

   // Lane to serve given which lanes have data and who was served last.
   // Only meaningful when at least one lane is non-empty.
   function automatic logic pick_lane(input logic ne0, input logic ne1,
                                      input logic last_grant);
      if (ne0 && ne1) begin
         return !last_grant;
      end else if (ne1) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/mux2to1_rr_sched_if.sv
// Lane-side and output-side signal bundle of the L2 scheduler.
//
// Handshake semantics: a lane byte transfers on a clk_4f edge where
// valid_bitN && readyN; readyN depends only on FIFO state, never on validN.
// valid_bitN with readyN low drops the byte and raises fifo_ovf. On the output
// side a byte transfers on an edge where valid_bit_out1 && out_ready; while
// valid_bit_out1 && !out_ready, data_out1 and selector are held stable.
interface mux2to1_rr_sched_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in0;
   logic              valid_bit0;
   logic              ready0;
   logic [DATA_W-1:0] in1;
   logic              valid_bit1;
   logic              ready1;
   logic              out_ready;
   logic              selector;
   logic [DATA_W-1:0] data_out1;
   logic              valid_bit_out1;
   logic              fifo_ovf;

   // Traffic source / sink side (L1 mux outputs and L2 serial stage)
   modport master (
      output in0, valid_bit0, in1, valid_bit1, out_ready,
      input  ready0, ready1, selector, data_out1, valid_bit_out1, fifo_ovf
   );

   // Scheduler side
   modport slave (
      input  in0, valid_bit0, in1, valid_bit1, out_ready,
      output ready0, ready1, selector, data_out1, valid_bit_out1, fifo_ovf
   );
endinterface

// File: rtl/mux2to1_rr_sched_lane_fifo.sv
// Per-lane input FIFO. Head is combinational (rd_data), full/empty come from
// an AW+1 bit occupancy counter. Writes to a full FIFO and reads from an
// empty one are ignored, so full is decided before any same-cycle read.
module lane_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk_4f,
   input  logic              reset_L,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_wr;
   logic              do_rd;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   // Register FIFO state; reset empties the FIFO and clears storage
   always_ff @(posedge clk_4f) begin
      if (reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/mux2to1_rr_sched.sv
// Round-robin scheduler sharing the L2 2:1 byte mux between two lanes.
// Each lane feeds a small FIFO; every advancing cycle one non-empty lane is
// granted, its head byte is loaded into the registered output and the
// selector records which lane it came from.
module mux2to1_rr_sched
   import mux2to1_rr_sched_pkg::*;
#(
   parameter int DATA_W = DATA_W_L2,
   parameter int DEPTH  = DEPTH_L2,
   parameter int AW     = AW_L2
) (
   input  logic                clk_4f,
   input  logic                reset_L,
   mux2to1_rr_sched_if.slave   bus,
   output sched_state_e        dbg_state
);

   logic [DATA_W-1:0] head0, head1;
   logic              empty0, empty1;
   logic              full0, full1;
   logic              push0, push1;
   logic              pop0, pop1;
   logic              adv;
   logic              any_ne;
   logic              grant;

   sched_state_e      state_q, state_d;
   logic              sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_grant_q, last_grant_d;
   logic              ovf_q, ovf_d;

   assign push0 = bus.valid_bit0 && !full0;
   assign push1 = bus.valid_bit1 && !full1;

   lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .wr_en   (push0),
      .wr_data (bus.in0),
      .rd_en   (pop0),
      .rd_data (head0),
      .empty   (empty0),
      .full    (full0)
   );

   lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .wr_en   (push1),
      .wr_data (bus.in1),
      .rd_en   (pop1),
      .rd_data (head1),
      .empty   (empty1),
      .full    (full1)
   );

   // Output register may take a new byte when it is empty or being consumed
   assign adv    = !valid_q || bus.out_ready;
   assign any_ne = !empty0 || !empty1;
   assign grant  = pick_lane(!empty0, !empty1, last_grant_q);
   assign pop0   = adv && any_ne && !grant;
   assign pop1   = adv && any_ne && grant;

   // Arbitration, output load, FSM next state and sticky overflow
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      data_d       = data_q;
      valid_d      = valid_q;
      last_grant_d = last_grant_q;
      ovf_d        = ovf_q
                     || (bus.valid_bit0 && full0)
                     || (bus.valid_bit1 && full1);
      if (adv) begin
         if (any_ne) begin
            data_d       = grant ? head1 : head0;
            valid_d      = 1'b1;
            sel_d        = grant;
            last_grant_d = grant;
            state_d      = ST_SEND;
         end else begin
            // Nothing to send: data and selector keep their last value
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      end
   end

   // Scheduler FSM and its registered outputs; last_grant resets to lane 1
   // so that lane 0 wins the first contested grant
   always_ff @(posedge clk_4f) begin
      if (reset_L) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         last_grant_q <= 1'b1;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         last_grant_q <= last_grant_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.ready0         = !full0;
   assign bus.ready1         = !full1;
   assign bus.selector       = sel_q;
   assign bus.data_out1      = data_q;
   assign bus.valid_bit_out1 = valid_q;
   assign bus.fifo_ovf       = ovf_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_mux2to1_rr_sched.sv
// Self-checking bench for mux2to1_rr_sched: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_mux2to1_rr_sched;
   import mux2to1_rr_sched_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic         clk_4f = 1'b0;
   logic         reset_L;
   sched_state_e dbg_state;

   always #5 clk_4f = ~clk_4f;

   mux2to1_rr_sched_if #(.DATA_W(DW)) sif ();

   mux2to1_rr_sched #(.DATA_W(DW), .DEPTH(DEPTH), .AW(2)) dut (
      .clk_4f    (clk_4f),
      .reset_L   (reset_L),
      .bus       (sif),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_sel;
   logic          m_last;
   logic          m_ovf;

   // Apply one clock edge and advance the model with the inputs seen at it
   task automatic tick();
      bit f0, f1, g, have;
      @(posedge clk_4f);
      if (reset_L) begin
         q0.delete();
         q1.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_sel   = 1'b0;
         m_last  = 1'b1;
         m_ovf   = 1'b0;
      end else begin
         f0 = (q0.size() == DEPTH);
         f1 = (q1.size() == DEPTH);
         if (!m_valid || sif.out_ready) begin
            have = (q0.size() > 0) || (q1.size() > 0);
            if (q0.size() > 0 && q1.size() > 0) g = !m_last;
            else g = (q1.size() > 0);
            if (have) begin
               m_data  = g ? q1.pop_front() : q0.pop_front();
               m_valid = 1'b1;
               m_sel   = g;
               m_last  = g;
            end else begin
               m_valid = 1'b0;
            end
         end
         if (sif.valid_bit0) begin
            if (f0) m_ovf = 1'b1;
            else q0.push_back(sif.in0);
         end
         if (sif.valid_bit1) begin
            if (f1) m_ovf = 1'b1;
            else q1.push_back(sif.in1);
         end
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      sif.valid_bit0 = 1'b0;
      sif.valid_bit1 = 1'b0;
      sif.in0        = '0;
      sif.in1        = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset_L = 1'b1;
      tick();
      reset_L = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_idle();
      sif.out_ready  = 1'b0;
      sif.valid_bit0 = 1'b1;
      sif.in0        = 8'h55;
      reset_L        = 1'b1;
      tick();
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", sif.valid_bit_out1); end
      n_checks++; if (sif.ready0 !== 1'b1) begin n_errors++; $display("FAIL reset_ready0: got %b exp 1", sif.ready0); end
      n_checks++; if (sif.ready1 !== 1'b1) begin n_errors++; $display("FAIL reset_ready1: got %b exp 1", sif.ready1); end
      n_checks++; if (sif.fifo_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b exp 0", sif.fifo_ovf); end
      n_checks++; if (sif.selector !== 1'b0) begin n_errors++; $display("FAIL reset_sel: got %b exp 0", sif.selector); end
      n_checks++; if (sif.data_out1 !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h exp 00", sif.data_out1); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      reset_L       = 1'b0;
      drive_idle();
      sif.out_ready = 1'b1;
      tick();
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0) begin n_errors++; $display("FAIL reset_nothing_queued: got %b exp 0", sif.valid_bit_out1); end
   endtask

   task automatic test_single_lane();
      drive_idle();
      sif.out_ready  = 1'b1;
      sif.valid_bit0 = 1'b1;
      sif.in0        = 8'hA1;
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0) begin n_errors++; $display("FAIL single_edge1_valid: got %b exp 0", sif.valid_bit_out1); end
      sif.in0 = 8'hA2;
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== 8'hA1) begin n_errors++; $display("FAIL single_edge2: got v=%b d=%h exp v=1 d=a1", sif.valid_bit_out1, sif.data_out1); end
      n_checks++; if (sif.selector !== 1'b0 || dbg_state !== ST_SEND) begin n_errors++; $display("FAIL single_edge2_sel_state: got sel=%b st=%0d exp sel=0 st=1", sif.selector, dbg_state); end
      drive_idle();
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== 8'hA2 || sif.selector !== 1'b0) begin n_errors++; $display("FAIL single_edge3: got v=%b d=%h s=%b exp v=1 d=a2 s=0", sif.valid_bit_out1, sif.data_out1, sif.selector); end
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0 || sif.data_out1 !== 8'hA2 || dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL single_drop: got v=%b d=%h st=%0d exp v=0 d=a2 st=0", sif.valid_bit_out1, sif.data_out1, dbg_state); end
   endtask

   task automatic test_alternation();
      logic [DW-1:0] exp_d [3];
      logic          exp_s [3];
      exp_d = '{8'h20, 8'h11, 8'h21};
      exp_s = '{1'b1, 1'b0, 1'b1};
      do_reset();
      sif.out_ready  = 1'b0;
      sif.valid_bit0 = 1'b1; sif.in0 = 8'h10;
      sif.valid_bit1 = 1'b1; sif.in1 = 8'h20;
      tick();
      sif.in0 = 8'h11;
      sif.in1 = 8'h21;
      tick();
      drive_idle();
      n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== 8'h10 || sif.selector !== 1'b0) begin n_errors++; $display("FAIL alt_first: got v=%b d=%h s=%b exp v=1 d=10 s=0", sif.valid_bit_out1, sif.data_out1, sif.selector); end
      tick();
      n_checks++; if (sif.data_out1 !== 8'h10) begin n_errors++; $display("FAIL alt_hold: got %h exp 10", sif.data_out1); end
      sif.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== exp_d[i] || sif.selector !== exp_s[i]) begin n_errors++; $display("FAIL alt_order[%0d]: got v=%b d=%h s=%b exp v=1 d=%h s=%b", i, sif.valid_bit_out1, sif.data_out1, sif.selector, exp_d[i], exp_s[i]); end
      end
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0) begin n_errors++; $display("FAIL alt_end: got %b exp 0", sif.valid_bit_out1); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] b [6];
      for (int k = 0; k < 6; k++) b[k] = DW'($urandom_range(0, 255));
      do_reset();
      sif.out_ready = 1'b0;
      // First byte lands in the output register, the next four fill the FIFO,
      // the sixth hits a full FIFO.
      for (int k = 0; k < 6; k++) begin
         sif.valid_bit1 = 1'b1;
         sif.in1        = b[k];
         tick();
         n_checks++; if (sif.ready1 !== (k < 4)) begin n_errors++; $display("FAIL bp_ready1[%0d]: got %b exp %b", k, sif.ready1, (k < 4)); end
         n_checks++; if (sif.fifo_ovf !== (k == 5)) begin n_errors++; $display("FAIL bp_ovf[%0d]: got %b exp %b", k, sif.fifo_ovf, (k == 5)); end
         if (k >= 1) begin
            n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== b[0]) begin n_errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h exp v=1 d=%h", k, sif.valid_bit_out1, sif.data_out1, b[0]); end
         end
      end
      drive_idle();
      sif.out_ready = 1'b1;
      for (int j = 1; j < 5; j++) begin
         tick();
         n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== b[j] || sif.selector !== 1'b1) begin n_errors++; $display("FAIL bp_drain[%0d]: got v=%b d=%h s=%b exp v=1 d=%h s=1", j, sif.valid_bit_out1, sif.data_out1, sif.selector, b[j]); end
      end
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0 || sif.fifo_ovf !== 1'b1) begin n_errors++; $display("FAIL bp_end: got v=%b ovf=%b exp v=0 ovf=1", sif.valid_bit_out1, sif.fifo_ovf); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] prev;
      logic [DW-1:0] cur;
      do_reset();
      sif.out_ready = 1'b1;
      prev = '0;
      for (int k = 0; k < 20; k++) begin
         cur            = DW'($urandom_range(0, 255));
         sif.valid_bit0 = 1'b1;
         sif.in0        = cur;
         tick();
         if (k >= 1) begin
            n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== prev) begin n_errors++; $display("FAIL b2b_data[%0d]: got v=%b d=%h exp v=1 d=%h", k, sif.valid_bit_out1, sif.data_out1, prev); end
            n_checks++; if (sif.ready0 !== 1'b1 || sif.fifo_ovf !== 1'b0) begin n_errors++; $display("FAIL b2b_flags[%0d]: got rdy=%b ovf=%b exp rdy=1 ovf=0", k, sif.ready0, sif.fifo_ovf); end
         end
         prev = cur;
      end
      drive_idle();
      tick();
      n_checks++; if (sif.data_out1 !== prev || sif.valid_bit_out1 !== 1'b1) begin n_errors++; $display("FAIL b2b_last: got v=%b d=%h exp v=1 d=%h", sif.valid_bit_out1, sif.data_out1, prev); end
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0) begin n_errors++; $display("FAIL b2b_empty: got %b exp 0", sif.valid_bit_out1); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      sif.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sif.valid_bit0 = 1'b1;
         sif.in0        = DW'(8'hC0 + k);
         tick();
      end
      reset_L        = 1'b1;
      sif.valid_bit0 = 1'b1;
      sif.out_ready  = 1'b1;
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0 || sif.data_out1 !== 8'h00 || sif.selector !== 1'b0) begin n_errors++; $display("FAIL rmid_out: got v=%b d=%h s=%b exp v=0 d=00 s=0", sif.valid_bit_out1, sif.data_out1, sif.selector); end
      n_checks++; if (sif.ready0 !== 1'b1 || sif.ready1 !== 1'b1 || sif.fifo_ovf !== 1'b0) begin n_errors++; $display("FAIL rmid_flags: got r0=%b r1=%b ovf=%b exp 1 1 0", sif.ready0, sif.ready1, sif.fifo_ovf); end
      reset_L = 1'b0;
      drive_idle();
      sif.valid_bit1 = 1'b1;
      sif.in1        = 8'h7E;
      tick();
      drive_idle();
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b1 || sif.data_out1 !== 8'h7E || sif.selector !== 1'b1) begin n_errors++; $display("FAIL rmid_first: got v=%b d=%h s=%b exp v=1 d=7e s=1", sif.valid_bit_out1, sif.data_out1, sif.selector); end
      tick();
      n_checks++; if (sif.valid_bit_out1 !== 1'b0) begin n_errors++; $display("FAIL rmid_stale: got %b exp 0", sif.valid_bit_out1); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         reset_L        = ($urandom_range(0, 99) == 0);
         sif.valid_bit0 = ($urandom_range(0, 2) != 0);
         sif.valid_bit1 = ($urandom_range(0, 2) != 0);
         sif.in0        = DW'($urandom_range(0, 255));
         sif.in1        = DW'($urandom_range(0, 255));
         sif.out_ready  = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         tick();
         n_checks++; if (sif.valid_bit_out1 !== m_valid) begin n_errors++; $display("FAIL rnd_valid c=%0d: got %b exp %b", c, sif.valid_bit_out1, m_valid); end
         n_checks++; if (sif.data_out1 !== m_data) begin n_errors++; $display("FAIL rnd_data c=%0d: got %h exp %h", c, sif.data_out1, m_data); end
         n_checks++; if (sif.selector !== m_sel) begin n_errors++; $display("FAIL rnd_sel c=%0d: got %b exp %b", c, sif.selector, m_sel); end
         n_checks++; if (sif.ready0 !== (q0.size() < DEPTH) || sif.ready1 !== (q1.size() < DEPTH)) begin n_errors++; $display("FAIL rnd_ready c=%0d: got %b%b exp %b%b", c, sif.ready0, sif.ready1, (q0.size() < DEPTH), (q1.size() < DEPTH)); end
         n_checks++; if (sif.fifo_ovf !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf c=%0d: got %b exp %b", c, sif.fifo_ovf, m_ovf); end
         n_checks++; if (dbg_state !== (m_valid ? ST_SEND : ST_IDLE)) begin n_errors++; $display("FAIL rnd_state c=%0d: got %0d exp %0d", c, dbg_state, m_valid); end
      end
      reset_L = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset_L       = 1'b1;
      sif.out_ready = 1'b0;
      drive_idle();
      test_reset();
      test_single_lane();
      test_alternation();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
